// File: rtl/mands_pkg.sv
// Shared types and widths for the MandS frame transmitter.
// Optional reference model is enabled with the MANDS_TX_REF_EN macro.
package mands_pkg;

    localparam int DATA_W = 8;   // signed sample width
    localparam int SUM_W  = 12;  // downstream sum width (16 x 8-bit cannot overflow)

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2,
        GAP    = 2'd3
    } tx_state_t;

endpackage

// File: rtl/mands_frame_tx_if.sv
// Bus bundle between upstream sample logic / MandS and the frame transmitter.
// exp_max/exp_sum exist only when MANDS_TX_REF_EN is defined.
//
// Handshake: there is no ready. MandS always accepts, so a sample is
// transferred in every cycle where valid=1; data is meaningless when valid=0.
// start is a single-cycle pulse one cycle before the first valid sample.
// Writes use wr_en alone; a write while full (with no same-cycle pop) is dropped
// and reported on err.
interface mands_frame_tx_if #(
    parameter int LEN_W = 5
);
    import mands_pkg::*;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic [LEN_W-1:0]  count;
    logic              send;
    logic [LEN_W-1:0]  frame_len;
    logic              start;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              err;
`ifdef MANDS_TX_REF_EN
    logic [DATA_W-1:0] exp_max;
    logic [SUM_W-1:0]  exp_sum;
`endif

    // Transmitter side
    modport master (
        input  wr_en, wr_data, send, frame_len,
`ifdef MANDS_TX_REF_EN
        output exp_max, exp_sum,
`endif
        output full, count, start, valid, data, busy, done, err
    );

    // Upstream producer / MandS side
    modport slave (
        output wr_en, wr_data, send, frame_len,
`ifdef MANDS_TX_REF_EN
        input  exp_max, exp_sum,
`endif
        input  full, count, start, valid, data, busy, done, err
    );

endinterface

// File: rtl/mands_tx_fifo.sv
// Circular sample buffer for the frame transmitter. Simultaneous push and pop
// are both honoured, even when full; a push while full without a pop is dropped.
module mands_tx_fifo
    import mands_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LEN_W = 5
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [LEN_W-1:0]  count,
    output logic              full,
    output logic              wr_drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == LEN_W'(DEPTH));
    assign do_pop  = rd_en && (count != '0);
    assign do_push = wr_en && (!full || do_pop);
    assign wr_drop = wr_en && full && !do_pop;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mands_frame_tx.sv
// Frame transmitter in front of the MandS max/sum engine: buffers samples,
// then on send emits start, a frame of valid samples, and an idle gap.
// MANDS_TX_REF_EN adds a running max/sum reference of the current frame.
module mands_frame_tx
    import mands_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int LEN_W   = 5,
    parameter int MIN_GAP = 2
) (
    input  logic               clk,
    input  logic               resetb,
    mands_frame_tx_if.master   bus,
    output tx_state_t          dbg_state
);

    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    tx_state_t         state, state_nx;
    logic [LEN_W-1:0]  remain;
    logic [GAP_W-1:0]  gap_cnt;
    logic              gap_last;
    logic              accept;
    logic              reject;
    logic              len_ok;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              wr_drop;
    logic [DATA_W-1:0] data_hold;
    logic              err_q;

    mands_tx_fifo #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_fifo (
        .clk     (clk),
        .resetb  (resetb),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .count   (bus.count),
        .full    (bus.full),
        .wr_drop (wr_drop)
    );

    assign len_ok   = (bus.frame_len != '0) && (bus.frame_len <= LEN_W'(DEPTH))
                      && (bus.count >= bus.frame_len);
    assign gap_last = (gap_cnt == GAP_W'(MIN_GAP - 1));
    assign rd_en    = (state == STREAM);

    // Outputs decode registered state only, so nothing is combinational from an input.
    assign bus.start = (state == START);
    assign bus.valid = (state == STREAM);
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == GAP) && gap_last;
    assign bus.err   = err_q;
    assign bus.data  = (state == STREAM) ? rd_data : data_hold;
    assign dbg_state = state;

    // Next-state logic; send outside IDLE is deliberately ignored.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.send) begin
                    if (len_ok) begin
                        accept   = 1'b1;
                        state_nx = START;
                    end else begin
                        reject   = 1'b1;
                    end
                end
            end
            START:   state_nx = STREAM;
            STREAM:  if (remain == LEN_W'(1)) state_nx = GAP;
            GAP:     if (gap_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register plus frame/gap counters, error pulse and data hold.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            remain    <= '0;
            gap_cnt   <= '0;
            err_q     <= 1'b0;
            data_hold <= '0;
        end else begin
            state   <= state_nx;
            err_q   <= reject || wr_drop;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (accept)
                remain <= bus.frame_len;
            else if (state == STREAM)
                remain <= remain - 1'b1;
            if (state == STREAM) data_hold <= rd_data;
        end
    end

`ifdef MANDS_TX_REF_EN
    logic              first_q;
    logic [DATA_W-1:0] ref_max;
    logic [SUM_W-1:0]  ref_sum;

    assign bus.exp_max = ref_max;
    assign bus.exp_sum = ref_sum;

    // Golden running max/sum: cleared on acceptance, first sample seeds the max.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            first_q <= 1'b0;
            ref_max <= '0;
            ref_sum <= '0;
        end else begin
            first_q <= (state == START);
            if (accept) begin
                ref_max <= '0;
                ref_sum <= '0;
            end else if (state == STREAM) begin
                if (first_q || ($signed(rd_data) > $signed(ref_max)))
                    ref_max <= rd_data;
                ref_sum <= ref_sum + {{(SUM_W - DATA_W){rd_data[DATA_W-1]}}, rd_data};
            end
        end
    end
`endif

endmodule

// File: tb/tb_mands_frame_tx.sv
// Directed bench for mands_frame_tx; reference-model checks compile in
// when MANDS_TX_REF_EN is defined.
module tb_mands_frame_tx;
    import mands_pkg::*;

    localparam int DEPTH   = 16;
    localparam int LEN_W   = 5;
    localparam int MIN_GAP = 2;

    // clock / reset
    logic clk    = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    mands_frame_tx_if #(.LEN_W(LEN_W)) bus ();
    tx_state_t dbg_state;

    mands_frame_tx #(.DEPTH(DEPTH), .LEN_W(LEN_W), .MIN_GAP(MIN_GAP)) dut (
        .clk       (clk),
        .resetb    (resetb),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // driver: one push; the expected queue decides whether it must be dropped
    task automatic push(input logic [7:0] v);
        bit drop;
        drop = (exp_q.size() == DEPTH);
        bus.wr_en   = 1'b1;
        bus.wr_data = v;
        tick();
        bus.wr_en   = 1'b0;
        if (!drop) exp_q.push_back(v);
        chk("push_err",   16'(bus.err),   16'(drop));
        chk("push_count", 16'(bus.count), 16'(exp_q.size()));
        chk("push_full",  16'(bus.full),  16'(exp_q.size() == DEPTH));
    endtask

    // driver + scoreboard: one complete frame from send to return to IDLE
    task automatic send_frame(input int len, input bit push_mid, input logic [7:0] pv,
                              input bit send_gap);
        logic [7:0]  e;
        logic [7:0]  last;
        logic [7:0]  mmax;
        logic [11:0] msum;
        last = 8'h00;
        mmax = 8'h00;
        msum = 12'h000;
        bus.send      = 1'b1;
        bus.frame_len = LEN_W'(len);
        tick();
        bus.send = 1'b0;
        chk("start_pulse", 16'(bus.start), 16'(1));
        chk("start_valid", 16'(bus.valid), 16'(0));
        chk("start_busy",  16'(bus.busy),  16'(1));
        chk("start_err",   16'(bus.err),   16'(0));
`ifdef MANDS_TX_REF_EN
        chk("start_exp_max", 16'(bus.exp_max), 16'(0));
        chk("start_exp_sum", 16'(bus.exp_sum), 16'(0));
`endif
        tick();
        for (int i = 0; i < len; i++) begin
            chk("stream_count", 16'(bus.count), 16'(exp_q.size()));
            e = exp_q.pop_front();
            chk("stream_valid", 16'(bus.valid), 16'(1));
            chk("stream_data",  16'(bus.data),  16'(e));
            chk("stream_start", 16'(bus.start), 16'(0));
            chk("stream_err",   16'(bus.err),   16'(0));
            if (i == 0 || $signed(e) > $signed(mmax)) mmax = e;
            msum = msum + {{4{e[7]}}, e};
            if (push_mid && i == 0) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = pv;
                exp_q.push_back(pv);
            end
            last = e;
            tick();
            bus.wr_en = 1'b0;
        end
        for (int g = 0; g < MIN_GAP; g++) begin
            chk("gap_valid", 16'(bus.valid), 16'(0));
            chk("gap_data",  16'(bus.data),  16'(last));
            chk("gap_done",  16'(bus.done),  16'(g == MIN_GAP - 1));
            chk("gap_busy",  16'(bus.busy),  16'(1));
            chk("gap_err",   16'(bus.err),   16'(0));
            if (send_gap && g == 0) begin
                bus.send      = 1'b1;
                bus.frame_len = LEN_W'(1);
            end
            tick();
            bus.send = 1'b0;
        end
        chk("idle_busy",  16'(bus.busy),  16'(0));
        chk("idle_done",  16'(bus.done),  16'(0));
        chk("idle_start", 16'(bus.start), 16'(0));
        chk("idle_err",   16'(bus.err),   16'(0));
        chk("idle_count", 16'(bus.count), 16'(exp_q.size()));
        chk("idle_state", 16'(dbg_state), 16'(IDLE));
`ifdef MANDS_TX_REF_EN
        chk("frame_exp_max", 16'(bus.exp_max), 16'(mmax));
        chk("frame_exp_sum", 16'(bus.exp_sum), 16'(msum));
`endif
    endtask

    task automatic reject_send(input int len);
        bus.send      = 1'b1;
        bus.frame_len = LEN_W'(len);
        tick();
        bus.send = 1'b0;
        chk("reject_err",   16'(bus.err),   16'(1));
        chk("reject_start", 16'(bus.start), 16'(0));
        chk("reject_busy",  16'(bus.busy),  16'(0));
        tick();
        chk("reject_err_clear", 16'(bus.err), 16'(0));
        chk("reject_start2",    16'(bus.start), 16'(0));
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] basic[9];
        basic = '{8'hFB, 8'hFE, 8'h03, 8'h01, 8'h07, 8'h00, 8'h01, 8'hFB, 8'h03};
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.send      = 1'b0;
        bus.frame_len = '0;

        // reset values
        resetb = 1'b0;
        tick();
        tick();
        chk("rst_start", 16'(bus.start), 16'(0));
        chk("rst_valid", 16'(bus.valid), 16'(0));
        chk("rst_data",  16'(bus.data),  16'(0));
        chk("rst_busy",  16'(bus.busy),  16'(0));
        chk("rst_done",  16'(bus.done),  16'(0));
        chk("rst_err",   16'(bus.err),   16'(0));
        chk("rst_full",  16'(bus.full),  16'(0));
        chk("rst_count", 16'(bus.count), 16'(0));
        chk("rst_state", 16'(dbg_state), 16'(IDLE));
`ifdef MANDS_TX_REF_EN
        chk("rst_exp_max", 16'(bus.exp_max), 16'(0));
        chk("rst_exp_sum", 16'(bus.exp_sum), 16'(0));
`endif
        resetb = 1'b1;
        tick();

        // basic 9-sample frame
        for (int i = 0; i < 9; i++) push(basic[i]);
        send_frame(9, 1'b0, 8'h00, 1'b0);
`ifdef MANDS_TX_REF_EN
        chk("basic_exp_max", 16'(bus.exp_max), 16'(8'h07));
        chk("basic_exp_sum", 16'(bus.exp_sum), 16'(12'h003));
`endif

        // short frame: -1, 5, -23
        push(8'hFF);
        push(8'h05);
        push(8'hE9);
        send_frame(3, 1'b0, 8'h00, 1'b0);
`ifdef MANDS_TX_REF_EN
        chk("short_exp_max", 16'(bus.exp_max), 16'(8'h05));
        chk("short_exp_sum", 16'(bus.exp_sum), 16'(12'hFED));
`endif

        // rejected sends: too long, zero, beyond depth
        push(8'h0A);
        push(8'h14);
        reject_send(4);
        reject_send(0);
        reject_send(17);
        chk("reject_count_kept", 16'(bus.count), 16'(2));
        send_frame(2, 1'b0, 8'h00, 1'b0);

        // full FIFO, dropped push, then a 16 x -128 frame with concurrent traffic
        for (int i = 0; i < DEPTH; i++) push(8'h80);
        chk("full_flag",  16'(bus.full),  16'(1));
        chk("full_count", 16'(bus.count), 16'(16));
        push(8'h11);
        tick();
        chk("drop_err_clear", 16'(bus.err),   16'(0));
        chk("drop_count",     16'(bus.count), 16'(16));
        send_frame(16, 1'b1, 8'h2A, 1'b1);
`ifdef MANDS_TX_REF_EN
        chk("full_exp_max", 16'(bus.exp_max), 16'(8'h80));
        chk("full_exp_sum", 16'(bus.exp_sum), 16'(12'h800));
`endif
        // the send issued during GAP was ignored; a new send now works
        send_frame(1, 1'b0, 8'h00, 1'b0);

        // reset in the middle of a 9-sample frame
        for (int i = 1; i <= 9; i++) push(8'(i));
        bus.send      = 1'b1;
        bus.frame_len = LEN_W'(9);
        tick();
        bus.send = 1'b0;
        tick();
        for (int i = 1; i <= 3; i++) begin
            chk("pre_rst_data", 16'(bus.data), 16'(i));
            tick();
        end
        chk("pre_rst_valid", 16'(bus.valid), 16'(1));
        chk("pre_rst_data4", 16'(bus.data),  16'(4));
        #2;
        resetb = 1'b0;
        #1;
        chk("midrst_valid", 16'(bus.valid), 16'(0));
        chk("midrst_count", 16'(bus.count), 16'(0));
        chk("midrst_busy",  16'(bus.busy),  16'(0));
        chk("midrst_state", 16'(dbg_state), 16'(IDLE));
        exp_q.delete();
        tick();
        chk("midrst_done1", 16'(bus.done), 16'(0));
        tick();
        chk("midrst_done2", 16'(bus.done), 16'(0));
        resetb = 1'b1;
        tick();
        chk("postrst_state", 16'(dbg_state), 16'(IDLE));
        chk("postrst_done",  16'(bus.done),  16'(0));
        chk("postrst_count", 16'(bus.count), 16'(0));

        // normal frame after reset recovery
        push(8'h7F);
        push(8'h81);
        send_frame(2, 1'b0, 8'h00, 1'b0);
`ifdef MANDS_TX_REF_EN
        chk("post_exp_max", 16'(bus.exp_max), 16'(8'h7F));
        chk("post_exp_sum", 16'(bus.exp_sum), 16'(12'h000));
`endif

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
